// File: rtl/joystick_input_ctrl_pkg.sv
// joystick_pkg: shared selection encodings and debounce defaults for the joystick front end
package joystick_pkg;
  localparam logic SEL_CONTINUE = 1'b0;
  localparam logic SEL_RESTART = 1'b1;
  localparam int DEBOUNCE_DEFAULT = 250000;
  localparam int CNT_W_DEFAULT = 18;
endpackage

// File: rtl/joystick_input_ctrl_if.sv
// joystick_input_ctrl_if: raw joystick lines in, conditioned enter/value and debounced levels out
interface joystick_input_ctrl_if;
  logic btn_raw;
  logic up_raw;
  logic down_raw;
  logic menu_active;
  logic enter;
  logic value;
  logic btn_level;
  logic up_level;
  logic down_level;
  modport master (
    output btn_raw, up_raw, down_raw, menu_active,
    input  enter, value, btn_level, up_level, down_level
  );
  modport slave (
    input  btn_raw, up_raw, down_raw, menu_active,
    output enter, value, btn_level, up_level, down_level
  );
endinterface

// File: rtl/joystick_input_ctrl_debouncer.sv
// input_debouncer: 2-FF synchroniser, polarity normalisation and counter debounce of one raw line
module input_debouncer
  import joystick_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press_pulse
);
  localparam logic IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;
  logic [1:0] sync_ff;
  logic [CNT_W-1:0] cnt;
  logic pressed;
  logic done;
  assign pressed = sync_ff[1] ^ IDLE;
  assign done = (pressed != stable) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  // press_pulse is raised on the same edge the new pressed level is accepted
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      sync_ff <= {IDLE, IDLE};
      cnt <= '0;
      stable <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], raw};
      cnt <= (pressed == stable || done) ? '0 : cnt + 1'b1;
      stable <= done ? pressed : stable;
      press_pulse <= done & pressed;
    end
endmodule

// File: rtl/joystick_input_ctrl.sv
// joystick_input_ctrl: debounces btn/up/down and produces the enter pulse and Pause Menu selection
module joystick_input_ctrl
  import joystick_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic clock,
  input logic reset,
  joystick_input_ctrl_if.slave js
);
  logic btn_press, up_press, down_press;
  logic enter_q, value_q;
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .ACTIVE_LOW(ACTIVE_LOW)) u_btn (
    .clock(clock), .reset(reset), .raw(js.btn_raw), .stable(js.btn_level), .press_pulse(btn_press)
  );
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .ACTIVE_LOW(ACTIVE_LOW)) u_up (
    .clock(clock), .reset(reset), .raw(js.up_raw), .stable(js.up_level), .press_pulse(up_press)
  );
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .ACTIVE_LOW(ACTIVE_LOW)) u_down (
    .clock(clock), .reset(reset), .raw(js.down_raw), .stable(js.down_level), .press_pulse(down_press)
  );
  // a button press freezes the selection so the FSM samples a stable value with enter
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      enter_q <= 1'b0;
      value_q <= SEL_CONTINUE;
    end else begin
      enter_q <= btn_press;
      value_q <= !js.menu_active ? SEL_CONTINUE :
                 (btn_press || (up_press && down_press)) ? value_q :
                 up_press ? SEL_CONTINUE :
                 down_press ? SEL_RESTART : value_q;
    end
  assign js.enter = enter_q;
  assign js.value = value_q;
endmodule

// File: tb/tb_joystick_input_ctrl.sv
// tb_joystick_input_ctrl: vector table, corner sequences and random stimulus against a window-based reference model
module tb_joystick_input_ctrl;
  import joystick_pkg::*;
  localparam int D = 4;
  localparam int W = D + 2;
  typedef struct {
    logic btn, up, dn, menu;
    int cyc;
    int pulses;
    logic val;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  joystick_input_ctrl_if js();
  joystick_input_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .ACTIVE_LOW(1'b1)) dut (
    .clock(clock), .reset(reset), .js(js.slave)
  );
  always #5 clock = ~clock;
  int n_checks = 0;
  int n_fail = 0;
  bit [W-1:0] win [3];
  bit [2:0] ms, mp;
  logic exp_enter, exp_value;
  vec_t tbl [17];
  task automatic check(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_int(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 3; i++) win[i] = '0;
    ms = '0;
    mp = '0;
    exp_enter = 1'b0;
    exp_value = SEL_CONTINUE;
  endtask
  // a line's accepted level flips once its last D synchronised samples all disagree with it
  task automatic model_step();
    bit [2:0] p;
    bit flip;
    p = {~js.down_raw, ~js.up_raw, ~js.btn_raw};
    exp_enter = mp[0];
    exp_value = !js.menu_active ? SEL_CONTINUE :
                (mp[0] || (mp[1] && mp[2])) ? exp_value :
                mp[1] ? SEL_CONTINUE : mp[2] ? SEL_RESTART : exp_value;
    for (int i = 0; i < 3; i++) begin
      win[i] = {win[i][W-2:0], p[i]};
      flip = ms[i] ? (win[i][W-1:2] == '0) : (&win[i][W-1:2]);
      mp[i] = flip && !ms[i];
      if (flip) ms[i] = ~ms[i];
    end
  endtask
  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check("enter", js.enter, exp_enter);
    check("value", js.value, exp_value);
    check("btn_level", js.btn_level, ms[0]);
    check("up_level", js.up_level, ms[1]);
    check("down_level", js.down_level, ms[2]);
  endtask
  task automatic drive(logic b, logic u, logic d, logic m);
    js.btn_raw = b;
    js.up_raw = u;
    js.down_raw = d;
    js.menu_active = m;
  endtask
  task automatic run(int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      pulses += int'(js.enter);
    end
  endtask
  task automatic wait_enter(int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (js.enter) begin
        n = i;
        break;
      end
    end
  endtask
  initial begin
    int n, cnt, hi;
    tbl = '{
      '{1'b1, 1'b1, 1'b1, 1'b1, 10, 0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b1, 10, 0, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b1, 10, 0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 1'b1, 10, 0, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b1, 10, 0, 1'b1},
      '{1'b1, 1'b0, 1'b1, 1'b1, 10, 0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b1, 10, 0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b1, 10, 0, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b1, 10, 0, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b0, 10, 0, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 10, 0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 10, 0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 10, 0, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 20, 1, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 20, 0, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 3, 0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 10, 0, 1'b0}
    };
    drive(1, 1, 1, 0);
    model_reset();
    #12;
    check("rst_enter", js.enter, 1'b0);
    check("rst_value", js.value, SEL_CONTINUE);
    check("rst_btn_level", js.btn_level, 1'b0);
    @(negedge clock) reset = 1'b1;
    js.btn_raw = 1'b0;
    wait_enter(30, n);
    check_int("enter_latency", n, D + 3);
    tick();
    check("enter_single", js.enter, 1'b0);
    run(13, cnt);
    check_int("held_extra_pulses", cnt, 0);
    js.btn_raw = 1'b1;
    run(15, cnt);
    check_int("release_pulses", cnt, 0);
    js.btn_raw = 1'b0;
    run(3, cnt);
    js.btn_raw = 1'b1;
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      cnt += int'(js.enter);
      hi += int'(js.btn_level);
    end
    check_int("glitch_pulses", cnt, 0);
    check_int("glitch_level", hi, 0);
    foreach (tbl[k]) begin
      drive(tbl[k].btn, tbl[k].up, tbl[k].dn, tbl[k].menu);
      run(tbl[k].cyc, cnt);
      check_int($sformatf("tbl%0d_pulses", k), cnt, tbl[k].pulses);
      check($sformatf("tbl%0d_value", k), js.value, tbl[k].val);
    end
    drive(1, 1, 1, 1);
    run(10, cnt);
    drive(0, 1, 0, 1);
    wait_enter(30, n);
    check_int("simul_found", int'(n > 0), 1);
    check("simul_value", js.value, SEL_CONTINUE);
    check("simul_down_level", js.down_level, 1'b1);
    tick();
    check("simul_hold", js.value, SEL_CONTINUE);
    drive(1, 1, 1, 0);
    run(10, cnt);
    js.btn_raw = 1'b0;
    run(4, cnt);
    reset = 1'b0;
    model_reset();
    #1;
    check("midrst_enter", js.enter, 1'b0);
    check("midrst_value", js.value, SEL_CONTINUE);
    check("midrst_level", js.btn_level, 1'b0);
    js.btn_raw = 1'b1;
    @(negedge clock) reset = 1'b1;
    run(15, cnt);
    check_int("midrst_pulses", cnt, 0);
    reset = 1'b0;
    js.btn_raw = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    run(20, cnt);
    check_int("held_across_reset_pulses", cnt, 1);
    js.btn_raw = 1'b1;
    run(10, cnt);
    for (int s = 0; s < 400; s++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? ~js.menu_active : js.menu_active);
      run($urandom_range(1, 8), cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
